dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Single-port data memory with a fixed-latency valid/ready request/response handshake.
// Decodes RV32I load/store sizes, rejects misaligned, out-of-range or illegal accesses.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy,
   output logic [15:0] err_count
);
   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

   state_t        state;
   logic [3:0]    cnt;
   logic          wr_q;
   logic [31:0]   addr_q;
   logic [2:0]    f3_q;
   logic [31:0]   wdata_q;
   logic [31:0]   mem [DEPTH_WORDS];

   logic          legal;
   logic          misalign;
   logic          out_of_range;
   logic          err;
   logic          access;
   logic [AW-1:0] idx;
   logic [31:0]   word;
   logic [7:0]    lane_b;
   logic [15:0]   lane_h;
   logic [31:0]   load_val;
   logic [3:0]    be;
   logic [31:0]   wword;

   always_comb begin
      legal = 1'b0;
      case (f3_q)
         3'b000, 3'b001, 3'b010: legal = 1'b1;
         3'b100, 3'b101:         legal = !wr_q;
         default:                legal = 1'b0;
      endcase
      misalign     = (f3_q[1:0] == 2'b01 && addr_q[0]) ||
                     (f3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
      out_of_range = |addr_q[31:AW+2];
      err          = !legal || misalign || out_of_range;
      access       = (state == StWait) && (cnt == 4'd0);

      idx    = addr_q[AW+1:2];
      word   = mem[idx];
      lane_b = word[{addr_q[1:0], 3'b000} +: 8];
      lane_h = addr_q[1] ? word[31:16] : word[15:0];

      load_val = '0;
      case (f3_q)
         3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
         3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
         3'b010:  load_val = word;
         3'b100:  load_val = {24'b0, lane_b};
         3'b101:  load_val = {16'b0, lane_h};
         default: load_val = '0;
      endcase

      // Store data is replicated across lanes so the byte enables alone pick the target.
      be    = 4'b1111;
      wword = wdata_q;
      case (f3_q[1:0])
         2'b00: begin
            be    = 4'b0001 << addr_q[1:0];
            wword = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            be    = addr_q[1] ? 4'b1100 : 4'b0011;
            wword = {2{wdata_q[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wword = wdata_q;
         end
      endcase
   end

   // Memory is deliberately outside the reset domain; reset only blocks a pending write.
   always_ff @(posedge clk) begin
      if (!reset && access && wr_q && !err) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= StIdle;
         cnt       <= 4'd0;
         req_ready <= 1'b1;
         busy      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
         err_count <= 16'd0;
      end else begin
         case (state)
            StIdle: begin
               if (req_valid) begin
                  wr_q      <= req_write;
                  addr_q    <= req_addr;
                  f3_q      <= req_funct3;
                  wdata_q   <= req_wdata;
                  cnt       <= 4'(LATENCY - 1);
                  state     <= StWait;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            StWait: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  state     <= StResp;
                  rsp_valid <= 1'b1;
                  rsp_err   <= err;
                  rsp_rdata <= (err || wr_q) ? 32'd0 : load_val;
               end
            end
            StResp: begin
               if (rsp_ready) begin
                  state     <= StIdle;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
                  if (rsp_err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
               end
            end
            default: begin
               state     <= StIdle;
               req_ready <= 1'b1;
               busy      <= 1'b0;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end
endmodule
